count_checker: RTL and testbench
================================

# count_checker

Self-checking run controller for the cycle-counter example top. It sits at the other end of the counter's `reset`/`count_c` interface: it drives the counter's reset, then reads the counter value every cycle and checks that it increments by exactly one. On a mismatch it reports the expected and actual values; after `RUN_CYCLES` correct samples it reports pass. The bench uses it to turn the free-running example into a checked, restartable run with sticky status outputs.

## Interface

- `RESET_CYCLES`, default 4, number of cycles `dut_reset` is held high after `start`; must be ≥ 1.
- `RUN_CYCLES`, default 100, number of counter samples checked before pass; must be ≥ 1.
- `MARK_VALUE`, default 50, counter value that sets `mark_hit`.
- `clk`, input, 1, sole clock; all logic is on the rising edge.
- `reset`, input, 1, asynchronous, active-high; forces the IDLE state and the reset values of all outputs.
- `start`, input, 1, single-cycle request to begin a run; sampled only in IDLE, PASS or FAIL.
- `dut_count`, input, 32, registered counter value from the DUT.
- `dut_reset`, output, 1, reset to the DUT counter.
- `busy`, output, 1, high in ASSERT_RST and RUN.
- `pass`, output, 1, sticky; set on successful completion.
- `fail`, output, 1, sticky; set on the first mismatch.
- `fail_expected`, output, 32, expected value captured at the mismatch.
- `fail_actual`, output, 32, `dut_count` captured at the mismatch.
- `mark_hit`, output, 1, sticky; `dut_count == MARK_VALUE` was seen during RUN.

## Operation

- States are IDLE, ASSERT_RST, RUN, PASS and FAIL. All outputs are registered.
- IDLE:
  - `dut_reset` = 1; `start` moves the block to ASSERT_RST.
- ASSERT_RST:
  - `dut_reset` = 1 and `busy` = 1.
  - Entry clears `pass`, `fail`, `mark_hit`, `fail_expected` and `fail_actual`.
  - `rst_cnt` counts to `RESET_CYCLES`, then the block moves to RUN with `exp` = 0.
- RUN:
  - `dut_reset` = 0 and `busy` = 1.
  - Each cycle compares `dut_count` with `exp`.
  - Equal: `exp` increments by 1 (32-bit, wraps modulo 2^32). After the `RUN_CYCLES`-th equal sample the block moves to PASS.
  - Not equal: `fail_expected` ← `exp`, `fail_actual` ← `dut_count`, then the block moves to FAIL.
  - `mark_hit` is set when `dut_count == MARK_VALUE`, whether or not that sample passes the compare.
- PASS / FAIL:
  - `dut_reset` = 1, which holds the DUT in reset.
  - `pass` or `fail` stays high.
  - `start` restarts the sequence at ASSERT_RST.
- `start` while `busy` is ignored.
- `pass` and `fail` are never high together.
- Reset values: state = IDLE, `dut_reset` = 1, and `busy`, `pass`, `fail`, `mark_hit` = 0, `fail_expected` = `fail_actual` = 0.

## Timing

- `start` sampled at edge E0 gives `busy` = 1 after E0.
- `dut_reset` is continuously high from IDLE through the `RESET_CYCLES` ASSERT_RST cycles, so the DUT sees a reset pulse of at least `RESET_CYCLES` cycles.
- The first RUN cycle is E0 + `RESET_CYCLES`. Its `dut_reset` = 0 appears after that edge.
- Within RUN the DUT sees reset low:
  - The first RUN sample is the reset value 0.
  - The k-th sample (k from 0) must equal k.
- Pass latency: `pass` rises at the edge that samples the last good value, i.e. `RESET_CYCLES` + `RUN_CYCLES` edges after the `start` edge. `busy` falls on the same edge.
- Fail latency: `fail` and the captured values appear at the edge that samples the bad value. No later sample is checked.
- Asserting `reset` mid-run takes effect immediately, without waiting for a clock edge:
  - state returns to IDLE;
  - `dut_reset` = 1;
  - all sticky outputs clear.
- A `start` coincident with the deassertion edge of `reset` is ignored.
- `start` in the same cycle as the final RUN sample is ignored, and the block enters PASS.

## Test plan

- Nominal run: defaults and an ideal counter, `start` pulse → `dut_reset` high for 4 cycles, then `pass` = 1 at 104 edges after `start`, `fail` = 0, `mark_hit` = 1.
- Injected error: counter forced to skip 37 → 39 → `fail` = 1 at the sample where 38 is expected, `fail_expected` = 38, `fail_actual` = 39, `pass` stays 0.
- Stuck reset: DUT ignores `dut_reset`, so the first RUN sample is 5 → `fail` on the first RUN cycle, `fail_expected` = 0, `fail_actual` = 5.
- Mid-run reset: `reset` asserted 20 cycles into RUN → outputs return to reset values immediately without a clock edge, state IDLE. A following `start` completes with `pass`.
- Restart and ignore: `start` pulsed during RUN → no effect. `start` after PASS → `pass` clears at ASSERT_RST entry and a second full run passes.
- Parameter corner: `RUN_CYCLES` = 1, `RESET_CYCLES` = 1, `MARK_VALUE` = 500 → `pass` 2 edges after `start`, `mark_hit` = 0.

Source files
------------

// File: rtl/count_checker.sv
// count_checker: drives a counter's reset, then checks that it increments by one
// each cycle for RUN_CYCLES samples, reporting sticky pass/fail/mark status.
`default_nettype none

module count_checker #(
   parameter int unsigned RESET_CYCLES = 4,
   parameter int unsigned RUN_CYCLES   = 100,
   parameter int unsigned MARK_VALUE   = 50
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [31:0] dut_count,
   output logic        dut_reset,
   output logic        busy,
   output logic        pass,
   output logic        fail,
   output logic [31:0] fail_expected,
   output logic [31:0] fail_actual,
   output logic        mark_hit
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_ASSERT = 3'd1;
   localparam logic [2:0] S_RUN    = 3'd2;
   localparam logic [2:0] S_PASS   = 3'd3;
   localparam logic [2:0] S_FAIL   = 3'd4;

   localparam logic [31:0] C_RST_LAST = 32'(RESET_CYCLES - 1);
   localparam logic [31:0] C_RUN_LAST = 32'(RUN_CYCLES - 1);
   localparam logic [31:0] C_MARK     = 32'(MARK_VALUE);

   logic [2:0]  state_q, state_d;
   logic [31:0] rst_cnt_q, rst_cnt_d;
   logic [31:0] exp_q, exp_d;
   logic        dut_reset_q, dut_reset_d;
   logic        busy_q, busy_d;
   logic        pass_q, pass_d;
   logic        fail_q, fail_d;
   logic [31:0] fexp_q, fexp_d;
   logic [31:0] fact_q, fact_d;
   logic        mark_q, mark_d;

   always_comb begin
      state_d   = state_q;
      rst_cnt_d = rst_cnt_q;
      exp_d     = exp_q;
      pass_d    = pass_q;
      fail_d    = fail_q;
      fexp_d    = fexp_q;
      fact_d    = fact_q;
      mark_d    = mark_q;
      case (state_q)
         S_IDLE, S_PASS, S_FAIL: begin
            if (start) begin
               state_d   = S_ASSERT;
               rst_cnt_d = '0;
               pass_d    = 1'b0;
               fail_d    = 1'b0;
               mark_d    = 1'b0;
               fexp_d    = '0;
               fact_d    = '0;
            end
         end
         S_ASSERT: begin
            if (rst_cnt_q == C_RST_LAST) begin
               state_d = S_RUN;
               exp_d   = '0;
            end else begin
               rst_cnt_d = rst_cnt_q + 32'd1;
            end
         end
         S_RUN: begin
            // The mark is recorded even on the sample that fails the compare.
            if (dut_count == C_MARK) begin
               mark_d = 1'b1;
            end
            if (dut_count == exp_q) begin
               exp_d = exp_q + 32'd1;
               if (exp_q == C_RUN_LAST) begin
                  state_d = S_PASS;
                  pass_d  = 1'b1;
               end
            end else begin
               state_d = S_FAIL;
               fail_d  = 1'b1;
               fexp_d  = exp_q;
               fact_d  = dut_count;
            end
         end
         default: state_d = S_IDLE;
      endcase
      dut_reset_d = (state_d != S_RUN);
      busy_d      = (state_d == S_ASSERT) || (state_d == S_RUN);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         rst_cnt_q   <= '0;
         exp_q       <= '0;
         dut_reset_q <= 1'b1;
         busy_q      <= 1'b0;
         pass_q      <= 1'b0;
         fail_q      <= 1'b0;
         fexp_q      <= '0;
         fact_q      <= '0;
         mark_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         rst_cnt_q   <= rst_cnt_d;
         exp_q       <= exp_d;
         dut_reset_q <= dut_reset_d;
         busy_q      <= busy_d;
         pass_q      <= pass_d;
         fail_q      <= fail_d;
         fexp_q      <= fexp_d;
         fact_q      <= fact_d;
         mark_q      <= mark_d;
      end
   end

   assign dut_reset     = dut_reset_q;
   assign busy          = busy_q;
   assign pass          = pass_q;
   assign fail          = fail_q;
   assign fail_expected = fexp_q;
   assign fail_actual   = fact_q;
   assign mark_hit      = mark_q;

endmodule

`default_nettype wire

// File: tb/tb_count_checker.sv
// Bench for count_checker: a configurable counter model, directed vector table,
// randomized runs against a reference model, and reset/restart corner sequences.
`default_nettype none

module tb_count_checker;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic start_a = 1'b0, start_b = 1'b0;
   logic [31:0] cnt_a = '0, cnt_b = '0;
   logic dut_reset_a, busy_a, pass_a, fail_a, mark_a;
   logic dut_reset_b, busy_b, pass_b, fail_b, mark_b;
   logic [31:0] fexp_a, fact_a, fexp_b, fact_b;

   // counter model configuration: reset value and an optional skip (v -> v+2)
   logic [31:0] cfg_rv = '0;
   logic        cfg_skip_en = 1'b0;
   logic [31:0] cfg_skip_at = '0;

   int total = 0;
   int bad = 0;
   int sel = 0;

   always #5 clk = ~clk;

   count_checker u_dut_a (
      .clk(clk), .reset(reset), .start(start_a), .dut_count(cnt_a),
      .dut_reset(dut_reset_a), .busy(busy_a), .pass(pass_a), .fail(fail_a),
      .fail_expected(fexp_a), .fail_actual(fact_a), .mark_hit(mark_a)
   );

   count_checker #(.RESET_CYCLES(1), .RUN_CYCLES(1), .MARK_VALUE(500)) u_dut_b (
      .clk(clk), .reset(reset), .start(start_b), .dut_count(cnt_b),
      .dut_reset(dut_reset_b), .busy(busy_b), .pass(pass_b), .fail(fail_b),
      .fail_expected(fexp_b), .fail_actual(fact_b), .mark_hit(mark_b)
   );

   always_ff @(posedge clk) begin
      if (dut_reset_a) cnt_a <= cfg_rv;
      else if (cfg_skip_en && cnt_a == cfg_skip_at) cnt_a <= cnt_a + 32'd2;
      else cnt_a <= cnt_a + 32'd1;
   end

   always_ff @(posedge clk) begin
      if (dut_reset_b) cnt_b <= cfg_rv;
      else if (cfg_skip_en && cnt_b == cfg_skip_at) cnt_b <= cnt_b + 32'd2;
      else cnt_b <= cnt_b + 32'd1;
   end

   wire        m_dut_reset = (sel != 0) ? dut_reset_b : dut_reset_a;
   wire        m_busy      = (sel != 0) ? busy_b : busy_a;
   wire        m_pass      = (sel != 0) ? pass_b : pass_a;
   wire        m_fail      = (sel != 0) ? fail_b : fail_a;
   wire        m_mark      = (sel != 0) ? mark_b : mark_a;
   wire [31:0] m_fexp      = (sel != 0) ? fexp_b : fexp_a;
   wire [31:0] m_fact      = (sel != 0) ? fact_b : fact_a;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: actual=%0d required=%0d", name, act, req);
      end
   endtask

   task automatic set_start(input logic v);
      if (sel != 0) start_b = v;
      else start_a = v;
   endtask

   // Reference: sample k of the counter is rv + k, plus one once the skip value
   // has been passed; the run fails at the first sample that differs from k.
   function automatic void ref_model(input int r, input int n, input logic [31:0] mark,
                                     input logic [31:0] rv, input bit sk_en,
                                     input logic [31:0] sk_at,
                                     output bit p, output bit f, output logic [31:0] fe,
                                     output logic [31:0] fa, output bit mk, output int lat);
      logic [31:0] s;
      p = 0; f = 0; fe = '0; fa = '0; mk = 0; lat = 0;
      for (int k = 0; k < n; k++) begin
         s = rv + 32'(k);
         if (sk_en && sk_at >= rv && 32'(k) > sk_at - rv) s = s + 32'd1;
         if (s == mark) mk = 1;
         if (s != 32'(k)) begin
            f = 1; fe = 32'(k); fa = s; lat = r + k + 1;
            return;
         end
      end
      p = 1;
      lat = r + n;
   endfunction

   task automatic run_scen(input int inst, input string nm, input logic [31:0] rv,
                           input bit sk_en, input logic [31:0] sk_at, input int ign_at,
                           input bit ep, input bit ef, input logic [31:0] efe,
                           input logic [31:0] efa, input bit emk, input int elat);
      int r, n, first_low;
      bit both;
      r = (inst != 0) ? 1 : 4;
      sel = inst;
      @(negedge clk);
      cfg_rv = rv; cfg_skip_en = sk_en; cfg_skip_at = sk_at;
      set_start(1'b1);
      @(negedge clk);
      set_start(1'b0);
      n = 0; first_low = -1; both = 0;
      chk({nm, ".busy_after_start"}, {31'd0, m_busy}, 32'd1);
      chk({nm, ".pass_cleared"}, {31'd0, m_pass}, 32'd0);
      chk({nm, ".fail_cleared"}, {31'd0, m_fail}, 32'd0);
      while (m_busy && n < 400) begin
         @(negedge clk);
         n++;
         set_start(n == ign_at);
         if (!m_dut_reset && first_low < 0) first_low = n;
         if (m_pass && m_fail) both = 1;
      end
      set_start(1'b0);
      chk({nm, ".latency"}, 32'(n), 32'(elat));
      chk({nm, ".reset_len"}, 32'(first_low), 32'(r));
      chk({nm, ".pass"}, {31'd0, m_pass}, {31'd0, ep});
      chk({nm, ".fail"}, {31'd0, m_fail}, {31'd0, ef});
      chk({nm, ".fail_expected"}, m_fexp, efe);
      chk({nm, ".fail_actual"}, m_fact, efa);
      chk({nm, ".mark_hit"}, {31'd0, m_mark}, {31'd0, emk});
      chk({nm, ".both_high"}, {31'd0, both}, 32'd0);
      chk({nm, ".dut_reset_held"}, {31'd0, m_dut_reset}, 32'd1);
   endtask

   typedef struct {
      int          inst;
      logic [31:0] rv;
      bit          sk_en;
      logic [31:0] sk_at;
      int          ign_at;
      bit          ep, ef;
      logic [31:0] efe, efa;
      bit          emk;
      int          elat;
   } vec_t;

   vec_t vecs[9];

   initial begin
      bit p, f, mk;
      logic [31:0] fe, fa, rv, sk_at;
      bit sk_en;
      int lat;

      //          inst rv   sk  at   ign  p  f  fexp fact mark lat
      vecs[0] = '{0,   0,   0,  0,   -1,  1, 0, 0,   0,   1,   104};
      vecs[1] = '{0,   0,   1,  37,  -1,  0, 1, 38,  39,  0,   43};
      vecs[2] = '{0,   5,   0,  0,   -1,  0, 1, 0,   5,   0,   5};
      vecs[3] = '{1,   0,   0,  0,   -1,  1, 0, 0,   0,   0,   2};
      vecs[4] = '{0,   0,   0,  0,   30,  1, 0, 0,   0,   1,   104};
      vecs[5] = '{0,   0,   0,  0,   -1,  1, 0, 0,   0,   1,   104};
      vecs[6] = '{1,   500, 0,  0,   -1,  0, 1, 0,   500, 1,   2};
      vecs[7] = '{0,   0,   1,  49,  -1,  0, 1, 50,  51,  0,   55};
      vecs[8] = '{0,   50,  0,  0,   -1,  0, 1, 0,   50,  1,   5};

      repeat (3) @(negedge clk);
      chk("reset.dut_reset_a", {31'd0, dut_reset_a}, 32'd1);
      chk("reset.busy_a", {31'd0, busy_a}, 32'd0);
      chk("reset.status_a", {29'd0, pass_a, fail_a, mark_a}, 32'd0);
      chk("reset.fexp_a", fexp_a, 32'd0);
      chk("reset.fact_a", fact_a, 32'd0);
      chk("reset.dut_reset_b", {31'd0, dut_reset_b}, 32'd1);
      chk("reset.status_b", {28'd0, busy_b, pass_b, fail_b, mark_b}, 32'd0);

      // start held through an edge while reset is still high is ignored
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      reset = 1'b0;
      @(negedge clk);
      chk("start_in_reset.busy", {31'd0, busy_a}, 32'd0);
      chk("start_in_reset.dut_reset", {31'd0, dut_reset_a}, 32'd1);

      for (int i = 0; i < 9; i++) begin
         run_scen(vecs[i].inst, $sformatf("vec%0d", i), vecs[i].rv, vecs[i].sk_en,
                  vecs[i].sk_at, vecs[i].ign_at, vecs[i].ep, vecs[i].ef, vecs[i].efe,
                  vecs[i].efa, vecs[i].emk, vecs[i].elat);
      end

      // sticky failure cleared asynchronously by reset (vec8 left instance A in FAIL)
      sel = 0;
      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      chk("async_clr.fail", {31'd0, fail_a}, 32'd0);
      chk("async_clr.mark", {31'd0, mark_a}, 32'd0);
      chk("async_clr.fact", fact_a, 32'd0);
      @(negedge clk);
      reset = 1'b0;

      // mid-run reset: 20 cycles into RUN
      cfg_rv = '0; cfg_skip_en = 1'b0;
      @(negedge clk);
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      repeat (4 + 20) @(negedge clk);
      chk("midrun.busy_before", {31'd0, busy_a}, 32'd1);
      #2 reset = 1'b1;
      #1;
      chk("midrun.busy", {31'd0, busy_a}, 32'd0);
      chk("midrun.dut_reset", {31'd0, dut_reset_a}, 32'd1);
      chk("midrun.status", {29'd0, pass_a, fail_a, mark_a}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      run_scen(0, "after_midrun", 0, 0, 0, -1, 1, 0, 0, 0, 1, 104);

      // randomized runs on instance A against the reference model
      for (int i = 0; i < 12; i++) begin
         rv = ($urandom_range(0, 9) < 7) ? 32'd0 : 32'($urandom_range(0, 60));
         sk_en = $urandom_range(0, 1) == 1;
         sk_at = 32'($urandom_range(0, 120));
         ref_model(4, 100, 32'd50, rv, sk_en, sk_at, p, f, fe, fa, mk, lat);
         run_scen(0, $sformatf("rand%0d", i), rv, sk_en, sk_at, -1, p, f, fe, fa, mk, lat);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
